// File: rtl/ft600_bus_responder.sv
// rtl/ft600_bus_responder.sv - FT600 245-synchronous-FIFO chip-side bus emulator
// RX buffer feeds the controller from h2d; TX buffer captures controller writes to d2h.
module ft600_bus_responder #(
  parameter int AEXP   = 4,
  parameter int TX_PKT = 8,
  parameter int TX_GAP = 4
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        o_rxf_n,
  output logic        o_txe_n,
  input  logic        i_oe_n,
  input  logic        i_rd_n,
  input  logic        i_wr_n,
  input  logic [15:0] i_data_in,
  input  logic [1:0]  i_be_in,
  output logic [15:0] o_data_out,
  output logic [1:0]  o_be_out,
  output logic        o_data_oe,
  input  logic        i_h2d_valid,
  output logic        o_h2d_ready,
  input  logic [15:0] i_h2d_data,
  output logic        o_d2h_valid,
  input  logic        i_d2h_ready,
  output logic [15:0] o_d2h_data,
  output logic [1:0]  o_d2h_be,
  output logic [2:0]  o_err
);
  localparam int DEPTH = 1 << AEXP;
  localparam int PW    = (TX_PKT > 1) ? $clog2(TX_PKT) : 1;
  localparam int GW    = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
  localparam logic [AEXP:0]   DEPTH_C  = (AEXP+1)'(DEPTH);
  localparam logic [AEXP-1:0] PTR_ONE  = AEXP'(1);
  localparam logic [PW-1:0]   PKT_LAST = PW'(TX_PKT - 1);
  localparam logic [PW-1:0]   PKT_ONE  = PW'(1);
  localparam logic [GW-1:0]   GAP_LOAD = (TX_GAP > 0) ? GW'(TX_GAP - 1) : '0;
  localparam logic [GW-1:0]   GAP_ONE  = GW'(1);

  typedef enum logic {S_OPEN, S_GAP} state_t;

  logic [15:0]     r_rx_mem [DEPTH];
  logic [17:0]     r_tx_mem [DEPTH];
  logic [AEXP-1:0] r_rx_wptr, r_rx_rptr, r_tx_wptr, r_tx_rptr;
  logic [AEXP:0]   r_rx_cnt, r_tx_cnt;
  logic            r_rxf_n, r_txe_n, r_h2d_ready, r_data_oe;
  logic [2:0]      r_err;
  state_t          r_state;
  logic [PW-1:0]   r_pkt_cnt;
  logic [GW-1:0]   r_gap_cnt;

  logic            w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
  logic [AEXP:0]   w_rx_cnt_next, w_tx_cnt_next;
  state_t          w_state_next;
  logic [PW-1:0]   w_pkt_cnt_next;
  logic [GW-1:0]   w_gap_cnt_next;

  // Strobes are qualified by the registered flags, so illegal strobes never touch a buffer.
  assign w_rx_push     = i_h2d_valid & r_h2d_ready;
  assign w_rx_pop      = ~i_oe_n & ~i_rd_n & ~r_rxf_n;
  assign w_tx_push     = ~i_wr_n & ~r_txe_n;
  assign w_tx_pop      = o_d2h_valid & i_d2h_ready;
  assign w_rx_cnt_next = r_rx_cnt + (AEXP+1)'(w_rx_push) - (AEXP+1)'(w_rx_pop);
  assign w_tx_cnt_next = r_tx_cnt + (AEXP+1)'(w_tx_push) - (AEXP+1)'(w_tx_pop);

  assign o_rxf_n     = r_rxf_n;
  assign o_txe_n     = r_txe_n;
  assign o_h2d_ready = r_h2d_ready;
  assign o_data_oe   = r_data_oe;
  assign o_err       = r_err;
  assign o_be_out    = 2'b11;
  assign o_data_out  = (r_rx_cnt != '0) ? r_rx_mem[r_rx_rptr] : 16'h0000;
  assign o_d2h_valid = (r_tx_cnt != '0);
  assign {o_d2h_be, o_d2h_data} = r_tx_mem[r_tx_rptr];

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= i_h2d_data;
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= {i_be_in, i_data_in};
  end

  always_comb begin
    w_state_next   = r_state;
    w_pkt_cnt_next = r_pkt_cnt;
    w_gap_cnt_next = r_gap_cnt;
    case (r_state)
      S_OPEN: begin
        if (w_tx_push) begin
          if (r_pkt_cnt == PKT_LAST) begin
            w_pkt_cnt_next = '0;
            if (TX_GAP > 0) begin
              w_state_next   = S_GAP;
              w_gap_cnt_next = GAP_LOAD;
            end
          end else begin
            w_pkt_cnt_next = r_pkt_cnt + PKT_ONE;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) w_state_next = S_OPEN;
        else                 w_gap_cnt_next = r_gap_cnt - GAP_ONE;
      end
      default: w_state_next = S_OPEN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_OPEN;
      r_pkt_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pkt_cnt <= w_pkt_cnt_next;
      r_gap_cnt <= w_gap_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_wptr   <= '0;
      r_rx_rptr   <= '0;
      r_tx_wptr   <= '0;
      r_tx_rptr   <= '0;
      r_rx_cnt    <= '0;
      r_tx_cnt    <= '0;
      r_rxf_n     <= 1'b1;
      r_txe_n     <= 1'b1;
      r_h2d_ready <= 1'b0;
      r_data_oe   <= 1'b0;
      r_err       <= 3'b000;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + PTR_ONE;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PTR_ONE;
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + PTR_ONE;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PTR_ONE;
      r_rx_cnt    <= w_rx_cnt_next;
      r_tx_cnt    <= w_tx_cnt_next;
      r_rxf_n     <= (w_rx_cnt_next == '0);
      r_h2d_ready <= (w_rx_cnt_next < DEPTH_C);
      r_txe_n     <= (w_tx_cnt_next == DEPTH_C) || (w_state_next == S_GAP);
      r_data_oe   <= ~i_oe_n;
      r_err       <= r_err | {~i_wr_n & r_data_oe, ~i_oe_n & ~i_rd_n & r_rxf_n, ~i_wr_n & r_txe_n};
    end
  end
endmodule

// File: tb/tb_ft600_bus_responder.sv
// tb/tb_ft600_bus_responder.sv - self-checking bench for ft600_bus_responder
// Directed table, corner sequences and randomized traffic against a queue-based model.
module tb_ft600_bus_responder;
  localparam int AEXP   = 4;
  localparam int DEPTH  = 16;
  localparam int TX_PKT = 8;
  localparam int TX_GAP = 4;

  typedef struct {
    logic        h2d_valid;
    logic [15:0] h2d_data;
    logic        oe_n;
    logic        rd_n;
    logic        exp_rxf_n;
    logic        exp_data_oe;
    logic [15:0] exp_data_out;
    logic [2:0]  exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        rxf_n, txe_n, data_oe, h2d_ready, d2h_valid;
  logic        oe_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, h2d_valid = 1'b0, d2h_ready = 1'b0;
  logic [15:0] data_in = 16'h0, h2d_data = 16'h0, data_out, d2h_data;
  logic [1:0]  be_in = 2'b11, be_out, d2h_be;
  logic [2:0]  err;

  int checks = 0;
  int errors = 0;

  logic [15:0] rxq[$];
  logic [17:0] txq[$];
  logic        m_rxf_n, m_txe_n, m_ready, m_oe;
  logic [2:0]  m_err;
  int          m_in_pkt, m_gap_left;

  vec_t        tbl[13];
  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];
  int          wcnt, hi, n;

  ft600_bus_responder #(.AEXP(AEXP), .TX_PKT(TX_PKT), .TX_GAP(TX_GAP)) dut (
    .clk(clk), .rstn(rstn),
    .o_rxf_n(rxf_n), .o_txe_n(txe_n),
    .i_oe_n(oe_n), .i_rd_n(rd_n), .i_wr_n(wr_n),
    .i_data_in(data_in), .i_be_in(be_in),
    .o_data_out(data_out), .o_be_out(be_out), .o_data_oe(data_oe),
    .i_h2d_valid(h2d_valid), .o_h2d_ready(h2d_ready), .i_h2d_data(h2d_data),
    .o_d2h_valid(d2h_valid), .i_d2h_ready(d2h_ready),
    .o_d2h_data(d2h_data), .o_d2h_be(d2h_be), .o_err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    rxq.delete();
    txq.delete();
    m_rxf_n = 1'b1; m_txe_n = 1'b1; m_ready = 1'b0; m_oe = 1'b0;
    m_err = 3'b000; m_in_pkt = 0; m_gap_left = 0;
  endtask

  // One bus clock in terms of the behavioural rules: queues, a packet counter and a gap timer.
  task automatic model_edge();
    logic rx_push, rx_pop, tx_push, tx_pop;
    rx_push = h2d_valid && m_ready;
    rx_pop  = !oe_n && !rd_n && !m_rxf_n;
    tx_push = !wr_n && !m_txe_n;
    tx_pop  = (txq.size() != 0) && d2h_ready;
    if (!wr_n && m_txe_n)          m_err[0] = 1'b1;
    if (!oe_n && !rd_n && m_rxf_n) m_err[1] = 1'b1;
    if (!wr_n && m_oe)             m_err[2] = 1'b1;
    if (rx_pop)  void'(rxq.pop_front());
    if (rx_push) rxq.push_back(h2d_data);
    if (tx_pop)  void'(txq.pop_front());
    if (tx_push) txq.push_back({be_in, data_in});
    if (m_gap_left > 0) m_gap_left--;
    else if (tx_push) begin
      m_in_pkt++;
      if (m_in_pkt == TX_PKT) begin
        m_in_pkt = 0;
        m_gap_left = TX_GAP;
      end
    end
    m_rxf_n = (rxq.size() == 0);
    m_ready = (rxq.size() < DEPTH);
    m_txe_n = (txq.size() == DEPTH) || (m_gap_left > 0);
    m_oe    = !oe_n;
  endtask

  task automatic check_model();
    chk("m_rxf_n", rxf_n, m_rxf_n);
    chk("m_txe_n", txe_n, m_txe_n);
    chk("m_h2d_ready", h2d_ready, m_ready);
    chk("m_data_oe", data_oe, m_oe);
    chk("m_err", err, m_err);
    chk("m_be_out", be_out, 2'b11);
    chk("m_data_out", data_out, (rxq.size() != 0) ? rxq[0] : 16'h0);
    chk("m_d2h_valid", d2h_valid, txq.size() != 0);
    if (txq.size() != 0) chk("m_d2h_word", {d2h_be, d2h_data}, txq[0]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic idle();
    h2d_valid = 1'b0; oe_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    d2h_ready = 1'b0; data_in = 16'h0; be_in = 2'b11;
  endtask

  // Asserted between clock edges so the reset values must appear without a clock.
  task automatic do_reset();
    #3;
    rstn = 1'b0;
    model_reset();
    idle();
    #1;
    chk("rst_rxf_n", rxf_n, 1);
    chk("rst_txe_n", txe_n, 1);
    chk("rst_data_oe", data_oe, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_be_out", be_out, 2'b11);
    chk("rst_h2d_ready", h2d_ready, 0);
    chk("rst_d2h_valid", d2h_valid, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 3'b000};
    tbl[1]  = '{1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 3'b000};
    tbl[2]  = '{1'b1, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 3'b000};
    tbl[3]  = '{1'b1, 16'h0003, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 3'b000};
    tbl[4]  = '{1'b1, 16'h0004, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 3'b000};
    tbl[5]  = '{1'b1, 16'h0005, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 3'b000};
    tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 3'b000};
    tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 3'b000};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 3'b000};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0004, 3'b000};
    tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 3'b000};
    tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 3'b000};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 3'b000};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      h2d_valid = tbl[i].h2d_valid;
      h2d_data  = tbl[i].h2d_data;
      oe_n      = tbl[i].oe_n;
      rd_n      = tbl[i].rd_n;
      step();
      chk($sformatf("tbl%0d_rxf_n", i), rxf_n, tbl[i].exp_rxf_n);
      chk($sformatf("tbl%0d_data_oe", i), data_oe, tbl[i].exp_data_oe);
      chk($sformatf("tbl%0d_data_out", i), data_out, tbl[i].exp_data_out);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
    end
    chk("first_cycle_h2d_ready", h2d_ready, 1);

    // Packetised writes: one flush gap after the 8th write, data in order.
    idle();
    d2h_ready = 1'b1;
    wcnt = 0; hi = 0;
    exp_q.delete(); got_q.delete();
    for (int c = 0; c < 60 && wcnt < 12; c++) begin
      if (d2h_valid) got_q.push_back({d2h_be, d2h_data});
      if (!m_txe_n) begin
        wr_n = 1'b0; data_in = 16'(16'h0100 + wcnt); be_in = 2'(wcnt);
        exp_q.push_back({be_in, data_in});
        wcnt++;
      end else wr_n = 1'b1;
      step();
      if (txe_n) hi++;
    end
    wr_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (d2h_valid) got_q.push_back({d2h_be, d2h_data});
      step();
    end
    chk("pkt_writes", wcnt, 12);
    chk("pkt_gap_cycles", hi, TX_GAP);
    chk("pkt_d2h_count", got_q.size(), 12);
    for (int i = 0; i < 12 && i < got_q.size(); i++)
      chk($sformatf("pkt_d2h_word%0d", i), got_q[i], exp_q[i]);
    chk("pkt_err", err, 0);

    // TX full: 16 writes with no drain, a 17th strobe flags err[0] and is dropped.
    do_reset();
    wcnt = 0;
    exp_q.delete();
    for (int c = 0; c < 80 && wcnt < DEPTH; c++) begin
      if (!m_txe_n) begin
        wr_n = 1'b0; data_in = 16'(16'h0200 + wcnt); be_in = 2'(wcnt + 1);
        exp_q.push_back({be_in, data_in});
        wcnt++;
      end else wr_n = 1'b1;
      step();
    end
    wr_n = 1'b1;
    chk("full_writes", wcnt, DEPTH);
    chk("full_txe_n_after16", txe_n, 1);
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("full_txe_n_hold%0d", c), txe_n, 1);
    end
    wr_n = 1'b0; data_in = 16'hDEAD;
    step();
    wr_n = 1'b1;
    chk("full_err0", err, 3'b001);
    d2h_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (d2h_valid) begin
        if (n < exp_q.size()) chk($sformatf("full_word%0d", n), {d2h_be, d2h_data}, exp_q[n]);
        n++;
      end
      step();
    end
    chk("full_drain_count", n, DEPTH);

    // Read from empty RX, then write during bus turnaround.
    do_reset();
    step();
    oe_n = 1'b0; rd_n = 1'b0;
    step();
    chk("empty_rd_err", err, 3'b010);
    chk("empty_rd_data_out", data_out, 0);
    chk("empty_rd_rxf_n", rxf_n, 1);
    rd_n = 1'b1; wr_n = 1'b0; data_in = 16'h5A5A;
    step();
    chk("contention_err", err, 3'b110);
    idle();
    step();

    // Reset in the middle of a flush gap with RX words pending.
    do_reset();
    step();
    for (int k = 0; k < 3; k++) begin
      h2d_valid = 1'b1; h2d_data = 16'(16'h00A0 + k);
      step();
    end
    h2d_valid = 1'b0; d2h_ready = 1'b1; wcnt = 0;
    for (int c = 0; c < 40 && wcnt < TX_PKT; c++) begin
      if (!m_txe_n) begin
        wr_n = 1'b0; data_in = 16'(16'h00B0 + wcnt); wcnt++;
      end else wr_n = 1'b1;
      step();
    end
    wr_n = 1'b1;
    step();
    chk("midgap_pre_txe_n", txe_n, 1);
    chk("midgap_pre_rxf_n", rxf_n, 0);
    do_reset();
    step();
    chk("midgap_post_rxf_n", rxf_n, 1);
    chk("midgap_post_txe_n", txe_n, 0);
    chk("midgap_post_h2d_ready", h2d_ready, 1);
    chk("midgap_post_data_out", data_out, 0);
    chk("midgap_post_d2h_valid", d2h_valid, 0);

    // Randomized traffic; the first two chunks keep every strobe legal.
    for (int ch = 0; ch < 4; ch++) begin
      do_reset();
      for (int c = 0; c < 500; c++) begin
        h2d_valid = ($urandom_range(0, 9) < 7);
        h2d_data  = 16'($urandom);
        oe_n      = ($urandom_range(0, 3) == 0);
        rd_n      = !($urandom_range(0, 9) < ((ch == 1) ? 1 : 5));
        wr_n      = !($urandom_range(0, 9) < 6);
        data_in   = 16'($urandom);
        be_in     = 2'($urandom);
        d2h_ready = ($urandom_range(0, 9) < ((ch == 1) ? 2 : 7));
        if (ch < 2) begin
          if (m_rxf_n) rd_n = 1'b1;
          if (m_txe_n || m_oe) wr_n = 1'b1;
        end
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ft600_bus_responder.md
FT600_BUS_RESPONDER -- requirements
Module: ft600_bus_responder

Synthesizable chip-side emulator of the FT600 16-bit 245-synchronous-FIFO bus. It responds to an FPGA-side 245-FIFO controller for loopback and self-test builds.

Interface
REQ-001 SHALL have parameter AEXP, default 4, meaning each internal buffer holds 2^AEXP words (DEPTH).
REQ-002 SHALL have parameter TX_PKT, default 8, meaning the number of accepted bus writes per packet before a flush gap.
REQ-003 SHALL have parameter TX_GAP, default 4, meaning txe_n is held high for this many cycles after each packet; 0 disables the gap.
REQ-004 clk  in  1  bus clock; also routed to the controller's usb_clk.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 rxf_n  out  1  low = read data available to the controller.
REQ-007 txe_n  out  1  low = space available for controller writes.
REQ-008 oe_n, rd_n, wr_n  in  1 each  controller strobes, active-low.
REQ-009 data_in  in  16  bus data driven by the controller.
REQ-010 be_in  in  2  byte enables driven by the controller.
REQ-011 data_out  out  16  bus data driven toward the controller.
REQ-012 be_out  out  2  byte enables driven toward the controller; constant 2'b11.
REQ-013 data_oe  out  1  tristate enable for data_out/be_out.
REQ-014 h2d_valid, h2d_ready  in/out  1 each  host-to-device stream handshake.
REQ-015 h2d_data  in  16  host-to-device word.
REQ-016 d2h_valid, d2h_ready  out/in  1 each  device-to-host stream handshake.
REQ-017 d2h_data, d2h_be  out  16/2  captured controller write, with its byte enables.
REQ-018 err  out  3  sticky protocol error flags.

Function
REQ-019 SHALL contain an RX buffer (h2d words to the bus) and a TX buffer ({be,data} from the bus to d2h); each buffer SHALL be DEPTH entries with an AEXP+1-bit count.
REQ-020 SHALL push h2d_data at a rising edge when h2d_valid and h2d_ready are both high.
REQ-021 h2d_ready SHALL be registered and equal (RX count_next < DEPTH).
REQ-022 A bus pop SHALL occur at an edge where oe_n=0, rd_n=0 and rxf_n=0, all as sampled at that edge.
REQ-023 rxf_n SHALL be registered: rxf_n <= (RX count_next == 0).
- After the last word is popped, rxf_n is high on the next cycle.
REQ-024 data_oe SHALL be registered as ~oe_n.
- The bus is driven starting 1 cycle after oe_n is sampled low.
- The bus is released 1 cycle after oe_n is sampled high.
REQ-025 data_out SHALL present the RX buffer head (first-word-fall-through), advance the cycle after each pop, and be 0 while the buffer is empty.
REQ-026 A bus push of {be_in,data_in} SHALL occur at an edge where wr_n=0 and txe_n=0.
REQ-027 d2h_valid SHALL equal (TX count != 0), with d2h_data/d2h_be taken from the TX head; a pop occurs when d2h_valid and d2h_ready are both high.
REQ-028 TX flush FSM SHALL have two states, OPEN and GAP, with pkt_cnt and gap_cnt counters:
- In OPEN, each push increments pkt_cnt.
- A push with pkt_cnt == TX_PKT-1 and TX_GAP > 0 SHALL enter GAP, clear pkt_cnt and load gap_cnt = TX_GAP-1.
- When TX_GAP == 0, pkt_cnt SHALL wrap to 0 and the FSM SHALL stay in OPEN.
REQ-029 In GAP, gap_cnt SHALL decrement each cycle, and the FSM SHALL return to OPEN at the edge where gap_cnt == 0.
REQ-030 txe_n SHALL be registered: txe_n <= (TX count_next == DEPTH) OR (state_next == GAP).
REQ-031 A simultaneous push and pop on either buffer SHALL leave its count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-032 Strobes that do not meet the push/pop conditions SHALL NOT change any buffer; they set error flags instead:
- err[0] is set by wr_n=0 while txe_n=1.
- err[1] is set by oe_n=0 and rd_n=0 while rxf_n=1.
- err[2] is set by wr_n=0 while data_oe=1 (bus contention).
REQ-033 err bits SHALL remain set until reset.

Reset
REQ-034 On rstn low, asynchronously and regardless of any bus transfer in progress, the block SHALL set:
- rxf_n=1, txe_n=1, data_oe=0, data_out=0, be_out=2'b11;
- h2d_ready=0, d2h_valid=0, err=0;
- FSM=OPEN, and all counts, pointers, pkt_cnt and gap_cnt = 0.
REQ-035 Buffered data SHALL be discarded on reset.
REQ-036 The first cycle after release SHALL register h2d_ready=1 and txe_n=0.

Verification
REQ-037 Push h2d 0x0001..0x0005; controller holds oe_n low, then rd_n low for 5 cycles -> data_out sequence is 0001..0005, and rxf_n goes high the cycle after the 5th pop.
REQ-038 With TX_PKT=8 and TX_GAP=4, controller writes continuously with d2h_ready=1 -> txe_n goes high after the 8th write for exactly 4 cycles, d2h_data reproduces the writes in order, and err=0.
REQ-039 With d2h_ready=0 and AEXP=4, 16 writes -> txe_n=1 the cycle after the 16th write; a 17th wr_n pulse sets err[0] and the TX count stays 16.
REQ-040 rd_n/oe_n low with an empty RX buffer -> err[1]=1, data_out=0, no count change; wr_n low while data_oe=1 -> err[2]=1.
REQ-041 Assert rstn mid-burst (RX count 3, FSM in GAP) -> all outputs reach their REQ-034 values immediately, and after release rxf_n stays 1 and txe_n=0.
